apb_completer_regfile: RTL

//  APB completer (slave) fronting a DATA_W-bit register file. It is the responder paired

---
 rtl/apb_completer_regfile_if.sv | 24 ++
 rtl/apb_completer_regfile.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/apb_completer_regfile_if.sv
// APB bus bundle between a requester (master) and the register-file completer (slave).
interface apb_completer_regfile_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic              pready;
    logic [DATA_W-1:0] prdata;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/apb_completer_regfile.sv
// APB completer fronting a DEPTH-entry register file with WAIT_CYCLES wait states,
// range/stability error detection and a saturating error counter.
module apb_completer_regfile #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned DEPTH       = 12,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic                    clk,
    input  logic                    rstn,
    apb_completer_regfile_if.slave  apb,
    output logic [7:0]              err_cnt
);

    localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic                viol_q, viol_d;
    logic                pready_q, pready_d;
    logic                pslverr_q, pslverr_d;
    logic [DATA_W-1:0]   prdata_q, prdata_d;
    logic [7:0]          err_cnt_q;
    logic [DATA_W-1:0]   regs_q [DEPTH];

    logic                err_now_c;
    logic                err_nx_c;
    logic                we_c;
    logic                err_done_c;

    // Error status of the transfer currently held in ACCESS.
    assign err_now_c = viol_q | ({1'b0, addr_q} >= DEPTH_L);

    // Next-state logic: setup decode, wait countdown, abort and completion.
    always_comb begin : fsm_comb
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wr_d       = wr_q;
        viol_d     = viol_q;
        we_c       = 1'b0;
        err_done_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apb.psel && !apb.penable) begin
                    addr_d  = apb.paddr;
                    wr_d    = apb.pwrite;
                    cnt_d   = CNT_W'(WAIT_CYCLES);
                    viol_d  = 1'b0;
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (!apb.psel || !apb.penable) begin
                    state_d = S_IDLE;
                    viol_d  = 1'b0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if ((apb.paddr != addr_q) || (apb.pwrite != wr_q)) begin
                        viol_d = 1'b1;
                    end
                end else begin
                    state_d    = S_IDLE;
                    viol_d     = 1'b0;
                    we_c       = wr_q && !err_now_c;
                    err_done_c = err_now_c;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Response values for the coming cycle, so the bus outputs are plain flops.
    always_comb begin : resp_comb
        pready_d  = (state_d == S_ACCESS) && (cnt_d == '0);
        err_nx_c  = viol_d | ({1'b0, addr_d} >= DEPTH_L);
        pslverr_d = pready_d && err_nx_c;
        prdata_d  = '0;
        if (pready_d && !wr_d && !err_nx_c) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (addr_d == ADDR_W'(i)) begin
                    prdata_d = regs_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin : ctrl_ff
        if (!rstn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            viol_q    <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            viol_q    <= viol_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (err_done_c && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // Register file; pwdata is taken on the completing edge.
    always_ff @(posedge clk or negedge rstn) begin : regs_ff
        if (!rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (we_c && (addr_q == ADDR_W'(i))) begin
                    regs_q[i] <= apb.pwdata;
                end
            end
        end
    end

    assign apb.pready  = pready_q;
    assign apb.pslverr = pslverr_q;
    assign apb.prdata  = prdata_q;
    assign err_cnt     = err_cnt_q;

endmodule
